// File: rtl/hssi_lane_reset_seq_if.sv
// Handshake/status bundle between the HSSI lane reset sequencer and its environment.
// The slave side is the sequencer; the master side drives SERDES status and seq_start.
interface hssi_lane_reset_seq_if #(
  parameter int NUM_LN = 4
);
  logic              seq_start;
  logic              tx_cal_busy;
  logic              rx_cal_busy;
  logic              tx_pll_locked;
  logic [NUM_LN-1:0] rx_is_lockedtodata;
  logic [NUM_LN-1:0] tx_analogreset;
  logic [NUM_LN-1:0] rx_analogreset;
  logic [NUM_LN-1:0] tx_digitalreset;
  logic [NUM_LN-1:0] rx_digitalreset;
  logic              link_ready;
  logic              seq_error;
  logic [2:0]        seq_state;
  logic [7:0]        relock_cnt;

  modport master (
    output seq_start, tx_cal_busy, rx_cal_busy, tx_pll_locked, rx_is_lockedtodata,
    input  tx_analogreset, rx_analogreset, tx_digitalreset, rx_digitalreset,
    input  link_ready, seq_error, seq_state, relock_cnt
  );

  modport slave (
    input  seq_start, tx_cal_busy, rx_cal_busy, tx_pll_locked, rx_is_lockedtodata,
    output tx_analogreset, rx_analogreset, tx_digitalreset, rx_digitalreset,
    output link_ready, seq_error, seq_state, relock_cnt
  );
endinterface

// File: rtl/hssi_lane_reset_seq.sv
// HSSI SERDES lane reset/bring-up sequencer on Clk_100: orders analog, TX digital and
// per-lane RX digital reset release behind calibration, PLL lock and CDR lock stability.
module hssi_lane_reset_seq #(
  parameter int NUM_LN       = 4,
  parameter int T_ANALOG     = 8,
  parameter int T_DIGITAL    = 4,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input logic                Clk_100,
  input logic                SoftReset_n,
  hssi_lane_reset_seq_if.slave bus
);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_TX_ANA   = 3'd1,
    S_WAIT_CAL = 3'd2,
    S_TX_DIG   = 3'd3,
    S_RX_LOCK  = 3'd4,
    S_READY    = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic [SW-1:0]     r_stab [NUM_LN];
  logic [SW-1:0]     w_stab_nxt [NUM_LN];
  logic [NUM_LN-1:0] r_rx_dig, w_rx_dig_nxt;
  logic [NUM_LN-1:0] r_tx_ana, r_rx_ana, r_tx_dig;
  logic [7:0]        r_relock, w_relock_nxt;
  logic              r_link, r_err;
  logic              w_cal_ok, w_ana_nxt, w_tx_dig_nxt;

  assign w_cal_ok = !bus.tx_cal_busy && !bus.rx_cal_busy && bus.tx_pll_locked;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer + TW'(1);
    w_rx_dig_nxt = r_rx_dig;
    w_relock_nxt = r_relock;
    for (int i = 0; i < NUM_LN; i++) w_stab_nxt[i] = '0;

    case (r_state)
      S_RESET: if (bus.seq_start) w_state_nxt = S_TX_ANA;
      S_TX_ANA: if (r_timer == TW'(T_ANALOG - 1)) w_state_nxt = S_WAIT_CAL;
      S_WAIT_CAL: begin
        if (w_cal_ok) w_state_nxt = S_TX_DIG;
        else if (r_timer == TW'(LOCK_TIMEOUT - 1)) w_state_nxt = S_ERROR;
      end
      S_TX_DIG: begin
        if (!bus.tx_pll_locked) begin
          w_state_nxt  = S_TX_ANA;
          w_relock_nxt = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;
        end else if (r_timer == TW'(T_DIGITAL - 1)) begin
          w_state_nxt = S_RX_LOCK;
        end
      end
      S_RX_LOCK: begin
        // Released lanes stay released; only lanes still in reset track lock stability.
        for (int i = 0; i < NUM_LN; i++) begin
          w_stab_nxt[i] = r_stab[i];
          if (r_rx_dig[i]) begin
            if (!bus.rx_is_lockedtodata[i])              w_stab_nxt[i] = '0;
            else if (r_stab[i] == SW'(LOCK_STABLE - 1))  w_rx_dig_nxt[i] = 1'b0;
            else                                         w_stab_nxt[i] = r_stab[i] + SW'(1);
          end
        end
        if (r_rx_dig == '0) w_state_nxt = S_READY;
        else if (r_timer == TW'(LOCK_TIMEOUT - 1)) w_state_nxt = S_ERROR;
      end
      S_READY: begin
        if (!bus.tx_pll_locked) begin
          w_state_nxt  = S_TX_ANA;
          w_relock_nxt = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;
        end else if (!(&bus.rx_is_lockedtodata)) begin
          w_state_nxt  = S_RX_LOCK;
          w_rx_dig_nxt = r_rx_dig | ~bus.rx_is_lockedtodata;
        end
      end
      S_ERROR: if (bus.seq_start) w_state_nxt = S_TX_ANA;
      default: w_state_nxt = S_RESET;
    endcase

    // A restart request overrides any in-flight decision and leaves the relock count alone.
    if (bus.seq_start && r_state != S_RESET && r_state != S_ERROR) begin
      w_state_nxt  = S_TX_ANA;
      w_relock_nxt = r_relock;
    end

    if (w_state_nxt != r_state) w_timer_nxt = '0;
    if (w_state_nxt != S_RX_LOCK && w_state_nxt != S_READY) w_rx_dig_nxt = '1;
  end

  assign w_ana_nxt    = (w_state_nxt == S_RESET) || (w_state_nxt == S_TX_ANA) ||
                        (w_state_nxt == S_ERROR);
  assign w_tx_dig_nxt = (w_state_nxt != S_RX_LOCK) && (w_state_nxt != S_READY);

  always_ff @(posedge Clk_100) begin
    if (!SoftReset_n) begin
      r_state  <= S_RESET;
      r_timer  <= '0;
      for (int i = 0; i < NUM_LN; i++) r_stab[i] <= '0;
      r_rx_dig <= '1;
      r_tx_ana <= '1;
      r_rx_ana <= '1;
      r_tx_dig <= '1;
      r_relock <= '0;
      r_link   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      for (int i = 0; i < NUM_LN; i++) r_stab[i] <= w_stab_nxt[i];
      r_rx_dig <= w_rx_dig_nxt;
      r_tx_ana <= {NUM_LN{w_ana_nxt}};
      r_rx_ana <= {NUM_LN{w_ana_nxt}};
      r_tx_dig <= {NUM_LN{w_tx_dig_nxt}};
      r_relock <= w_relock_nxt;
      r_link   <= (w_state_nxt == S_READY);
      r_err    <= (w_state_nxt == S_ERROR);
    end
  end

  assign bus.tx_analogreset  = r_tx_ana;
  assign bus.rx_analogreset  = r_rx_ana;
  assign bus.tx_digitalreset = r_tx_dig;
  assign bus.rx_digitalreset = r_rx_dig;
  assign bus.link_ready      = r_link;
  assign bus.seq_error       = r_err;
  assign bus.seq_state       = r_state;
  assign bus.relock_cnt      = r_relock;
endmodule

// File: tb/tb_hssi_lane_reset_seq.sv
// Directed bench for hssi_lane_reset_seq; cycle n is the interval after the nth edge,
// inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_hssi_lane_reset_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hssi_lane_reset_seq_if #(.NUM_LN(4)) bus ();

  hssi_lane_reset_seq #(
    .NUM_LN(4), .T_ANALOG(8), .T_DIGITAL(4), .LOCK_STABLE(16), .LOCK_TIMEOUT(64)
  ) u_dut (
    .Clk_100(clk),
    .SoftReset_n(rst_n),
    .bus(bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.seq_start          = 1'b0;
    bus.tx_cal_busy        = 1'b0;
    bus.rx_cal_busy        = 1'b0;
    bus.tx_pll_locked      = 1'b1;
    bus.rx_is_lockedtodata = 4'b1111;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  // Leaves the bench in cycle 1 (first TX_ANA cycle).
  task automatic start_seq();
    bus.seq_start = 1'b1;
    tick(1);
    bus.seq_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.seq_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.seq_state); end
    n_tests++; if ({bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset} !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_vectors: got %h expected ffff", {bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset}); end
    n_tests++; if ({bus.link_ready, bus.seq_error, bus.relock_cnt} !== 10'd0) begin
      n_fail++; $display("FAIL reset_status: got link=%b err=%b relock=%0d expected 0/0/0", bus.link_ready, bus.seq_error, bus.relock_cnt); end
    tick(5);
    n_tests++; if (bus.seq_state !== 3'd0) begin n_fail++; $display("FAIL reset_idle: got %0d expected 0", bus.seq_state); end
  endtask

  task automatic test_nominal();
    do_reset();
    start_seq();
    n_tests++; if (bus.seq_state !== 3'd1) begin n_fail++; $display("FAIL nom_tx_ana: got %0d expected 1", bus.seq_state); end
    tick(7);  // cycle 8
    n_tests++; if ({bus.tx_analogreset, bus.rx_analogreset} !== 8'hFF) begin n_fail++; $display("FAIL nom_ana_c8: got %h expected ff", {bus.tx_analogreset, bus.rx_analogreset}); end
    tick(1);  // cycle 9
    n_tests++; if ({bus.tx_analogreset, bus.rx_analogreset} !== 8'h00) begin n_fail++; $display("FAIL nom_ana_c9: got %h expected 00", {bus.tx_analogreset, bus.rx_analogreset}); end
    n_tests++; if (bus.seq_state !== 3'd2) begin n_fail++; $display("FAIL nom_wait_cal: got %0d expected 2", bus.seq_state); end
    tick(4);  // cycle 13
    n_tests++; if (bus.tx_digitalreset !== 4'hF) begin n_fail++; $display("FAIL nom_txdig_c13: got %h expected f", bus.tx_digitalreset); end
    tick(1);  // cycle 14
    n_tests++; if (bus.tx_digitalreset !== 4'h0 || bus.seq_state !== 3'd4) begin
      n_fail++; $display("FAIL nom_txdig_c14: got txdig=%h state=%0d expected 0/4", bus.tx_digitalreset, bus.seq_state); end
    tick(15); // cycle 29
    n_tests++; if (bus.rx_digitalreset !== 4'hF) begin n_fail++; $display("FAIL nom_rxdig_c29: got %h expected f", bus.rx_digitalreset); end
    tick(1);  // cycle 30
    n_tests++; if (bus.rx_digitalreset !== 4'h0 || bus.link_ready !== 1'b0) begin
      n_fail++; $display("FAIL nom_rxdig_c30: got rxdig=%h link=%b expected 0/0", bus.rx_digitalreset, bus.link_ready); end
    tick(1);  // cycle 31
    n_tests++; if (bus.link_ready !== 1'b1 || bus.seq_state !== 3'd5) begin
      n_fail++; $display("FAIL nom_ready: got link=%b state=%0d expected 1/5", bus.link_ready, bus.seq_state); end
  endtask

  task automatic test_staggered();
    do_reset();
    bus.rx_is_lockedtodata = 4'b1011;
    start_seq();
    tick(23); // cycle 24: lane 1 stab=10, glitch low
    bus.rx_is_lockedtodata = 4'b1001;
    tick(1);
    bus.rx_is_lockedtodata = 4'b1011;
    tick(5);  // cycle 30
    n_tests++; if (bus.rx_digitalreset !== 4'b0110) begin n_fail++; $display("FAIL stag_c30: got %b expected 0110", bus.rx_digitalreset); end
    tick(10); // cycle 40
    n_tests++; if (bus.rx_digitalreset !== 4'b0110) begin n_fail++; $display("FAIL stag_c40: got %b expected 0110", bus.rx_digitalreset); end
    tick(1);  // cycle 41
    n_tests++; if (bus.rx_digitalreset !== 4'b0100) begin n_fail++; $display("FAIL stag_c41: got %b expected 0100", bus.rx_digitalreset); end
    tick(3);  // cycle 44: lane 2 locks
    bus.rx_is_lockedtodata = 4'b1111;
    tick(15); // cycle 59
    n_tests++; if (bus.rx_digitalreset !== 4'b0100 || bus.link_ready !== 1'b0) begin
      n_fail++; $display("FAIL stag_c59: got rxdig=%b link=%b expected 0100/0", bus.rx_digitalreset, bus.link_ready); end
    tick(1);  // cycle 60
    n_tests++; if (bus.rx_digitalreset !== 4'b0000 || bus.link_ready !== 1'b0) begin
      n_fail++; $display("FAIL stag_c60: got rxdig=%b link=%b expected 0000/0", bus.rx_digitalreset, bus.link_ready); end
    tick(1);  // cycle 61
    n_tests++; if (bus.link_ready !== 1'b1) begin n_fail++; $display("FAIL stag_ready: got %b expected 1", bus.link_ready); end
  endtask

  task automatic test_cal_timeout();
    do_reset();
    bus.tx_cal_busy = 1'b1;
    start_seq();
    tick(71); // cycle 72: last WAIT_CAL cycle
    n_tests++; if (bus.seq_state !== 3'd2 || bus.seq_error !== 1'b0) begin
      n_fail++; $display("FAIL tmo_c72: got state=%0d err=%b expected 2/0", bus.seq_state, bus.seq_error); end
    tick(1);  // cycle 73
    n_tests++; if (bus.seq_state !== 3'd6 || bus.seq_error !== 1'b1) begin
      n_fail++; $display("FAIL tmo_c73: got state=%0d err=%b expected 6/1", bus.seq_state, bus.seq_error); end
    n_tests++; if ({bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset} !== 16'hFFFF) begin
      n_fail++; $display("FAIL tmo_vectors: got %h expected ffff", {bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset}); end
    tick(3);
    n_tests++; if (bus.seq_error !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", bus.seq_error); end
    bus.tx_cal_busy = 1'b0;
    start_seq();
    n_tests++; if (bus.seq_state !== 3'd1 || bus.seq_error !== 1'b0) begin
      n_fail++; $display("FAIL tmo_restart: got state=%0d err=%b expected 1/0", bus.seq_state, bus.seq_error); end
  endtask

  task automatic test_loss_ready();
    do_reset();
    start_seq();
    tick(30); // cycle 31, READY
    bus.rx_is_lockedtodata = 4'b0111;
    tick(1);  // cycle 32
    bus.rx_is_lockedtodata = 4'b1111;
    n_tests++; if (bus.rx_digitalreset !== 4'b1000 || bus.link_ready !== 1'b0 || bus.seq_state !== 3'd4) begin
      n_fail++; $display("FAIL loss_lane3: got rxdig=%b link=%b state=%0d expected 1000/0/4", bus.rx_digitalreset, bus.link_ready, bus.seq_state); end
    tick(15); // cycle 47
    n_tests++; if (bus.rx_digitalreset !== 4'b1000) begin n_fail++; $display("FAIL loss_c47: got %b expected 1000", bus.rx_digitalreset); end
    tick(1);  // cycle 48
    n_tests++; if (bus.rx_digitalreset !== 4'b0000) begin n_fail++; $display("FAIL loss_c48: got %b expected 0000", bus.rx_digitalreset); end
    tick(1);  // cycle 49
    n_tests++; if (bus.link_ready !== 1'b1) begin n_fail++; $display("FAIL loss_relink: got %b expected 1", bus.link_ready); end
    bus.tx_pll_locked = 1'b0;
    tick(1);  // cycle 50
    bus.tx_pll_locked = 1'b1;
    n_tests++; if (bus.seq_state !== 3'd1 || bus.relock_cnt !== 8'd1 || bus.link_ready !== 1'b0) begin
      n_fail++; $display("FAIL loss_pll: got state=%0d relock=%0d link=%b expected 1/1/0", bus.seq_state, bus.relock_cnt, bus.link_ready); end
    n_tests++; if ({bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset} !== 16'hFFFF) begin
      n_fail++; $display("FAIL loss_vectors: got %h expected ffff", {bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset}); end
  endtask

  // Continues from test_loss_ready: in the first TX_ANA cycle with relock_cnt=1.
  task automatic test_restart_and_reset();
    tick(19); // RX_LOCK
    n_tests++; if (bus.seq_state !== 3'd4) begin n_fail++; $display("FAIL rst_rxlock: got %0d expected 4", bus.seq_state); end
    start_seq();
    n_tests++; if (bus.seq_state !== 3'd1 || bus.relock_cnt !== 8'd1 || bus.tx_digitalreset !== 4'hF) begin
      n_fail++; $display("FAIL restart: got state=%0d relock=%0d txdig=%h expected 1/1/f", bus.seq_state, bus.relock_cnt, bus.tx_digitalreset); end
    tick(19);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    n_tests++; if (bus.seq_state !== 3'd0 || bus.relock_cnt !== 8'd0) begin
      n_fail++; $display("FAIL midrst: got state=%0d relock=%0d expected 0/0", bus.seq_state, bus.relock_cnt); end
    n_tests++; if ({bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset} !== 16'hFFFF) begin
      n_fail++; $display("FAIL midrst_vectors: got %h expected ffff", {bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset}); end
    tick(20);
    n_tests++; if (bus.seq_state !== 3'd0 || bus.tx_analogreset !== 4'hF) begin
      n_fail++; $display("FAIL midrst_hold: got state=%0d txana=%h expected 0/f", bus.seq_state, bus.tx_analogreset); end
  endtask

  task automatic test_saturation();
    do_reset();
    start_seq();
    tick(30);
    for (int k = 1; k <= 259; k++) begin
      bus.tx_pll_locked = 1'b0;
      tick(1);
      bus.tx_pll_locked = 1'b1;
      if (k == 254) begin
        n_tests++; if (bus.relock_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", bus.relock_cnt); end
      end
      tick(30);
    end
    n_tests++; if (bus.relock_cnt !== 8'd255 || bus.seq_state !== 3'd5) begin
      n_fail++; $display("FAIL sat_255: got relock=%0d state=%0d expected 255/5", bus.relock_cnt, bus.seq_state); end
    bus.tx_pll_locked      = 1'b0;
    bus.rx_is_lockedtodata = 4'b0111;
    tick(1);
    bus.tx_pll_locked      = 1'b1;
    bus.rx_is_lockedtodata = 4'b1111;
    n_tests++; if (bus.seq_state !== 3'd1 || bus.relock_cnt !== 8'd255) begin
      n_fail++; $display("FAIL simul: got state=%0d relock=%0d expected 1/255", bus.seq_state, bus.relock_cnt); end
    n_tests++; if ({bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset} !== 16'hFFFF) begin
      n_fail++; $display("FAIL simul_vectors: got %h expected ffff", {bus.tx_analogreset, bus.rx_analogreset, bus.tx_digitalreset, bus.rx_digitalreset}); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_nominal();
    test_staggered();
    test_cal_timeout();
    test_loss_ready();
    test_restart_and_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
